sha3_msg_packer: RTL and testbench
==================================

SHA3_MSG_PACKER -- requirements
Module: sha3_msg_packer

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data word width in bits; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port abort_i, input, 1, synchronous discard of the current message.
REQ-005 SHALL have port in_valid_i, input, 1, upstream beat valid.
REQ-006 SHALL have port in_ready_o, output, 1, beat accepted when in_valid_i & in_ready_o.
REQ-007 SHALL have port in_data_i, input, 32, little-endian bytes, LSB-aligned.
REQ-008 SHALL have port in_bytes_i, input, 3, count of valid bytes in in_data_i (0..4).
REQ-009 SHALL have port in_last_i, input, 1, final beat of the message.
REQ-010 SHALL have port out_valid_o, output, 1, packed word valid toward the SHA3 message FIFO write path.
REQ-011 SHALL have port out_ready_i, input, 1, downstream accepts when out_valid_o & out_ready_i.
REQ-012 SHALL have port out_data_o, output, 32, packed word; unused bytes are 0.
REQ-013 SHALL have port out_strb_o, output, 4, byte strobes, contiguous from bit 0.
REQ-014 SHALL have port out_last_o, output, 1, final word of the message.
REQ-015 SHALL have port msg_bytes_o, output, 32, bytes accepted in the current message.
REQ-016 SHALL have port err_o, output, 1, one-cycle pulse on an illegal beat.

Function
REQ-017 SHALL hold a residue register of 0-3 bytes with fill count fill[1:0].
REQ-018 SHALL implement states PACK and FLUSH.
REQ-019 In PACK, SHALL drive in_ready_o = !out_valid_o | out_ready_i.
REQ-020 In FLUSH, SHALL drive in_ready_o = 0.
REQ-021 SHALL use a single output register stage: a word SHALL appear on out_valid_o in the cycle after the beat that completes it.
REQ-022 SHALL hold out_valid_o, out_data_o, out_strb_o and out_last_o stable until the out_valid_o & out_ready_i handshake.
REQ-023 On an accepted beat, with total = fill + in_bytes_i, the byte order SHALL be residue bytes first, then in_data_i bytes.
REQ-024 If total >= 4, SHALL emit the lower 4 bytes with strb 1111, keep the upper total-4 bytes as residue, and set fill = total-4.
REQ-025 If total < 4 and in_last_i = 0, SHALL emit no word and set fill = total.
REQ-026 If in_last_i = 1 and total < 4, SHALL emit one word with strb = (1<<total)-1 and out_last_o = 1, then set fill = 0.
REQ-027 If in_last_i = 1 and total == 4, SHALL emit one word with strb 1111 and out_last_o = 1.
REQ-028 If in_last_i = 1 and total > 4, SHALL emit a full word with out_last_o = 0, enter FLUSH, then emit the residue with partial strb and out_last_o = 1.
REQ-029 On handshake of the FLUSH word, SHALL clear fill and return to PACK.
REQ-030 in_bytes_i = 0 SHALL be legal only with in_last_i = 1.
REQ-031 A legal zero-byte last beat with fill = 0 SHALL emit data 0, strb 0000, out_last_o = 1 (empty-message marker).
REQ-032 in_bytes_i > 4, or in_bytes_i = 0 with in_last_i = 0, SHALL pulse err_o for one cycle, SHALL drop the beat (state, fill and msg_bytes_o unchanged), and SHALL still count the beat as accepted.
REQ-033 SHALL add in_bytes_i to msg_bytes_o on each legal accepted beat, saturating at 0xFFFF_FFFF.
REQ-034 SHALL clear msg_bytes_o in the cycle after the out_last_o handshake.
REQ-035 abort_i SHALL take priority over everything else and, next cycle, clear out_valid_o, fill, residue and msg_bytes_o and set state to PACK; in_ready_o SHALL be 0 while abort_i = 1.
REQ-036 If a beat is accepted while the output register is draining (out_valid_o & out_ready_i), the register SHALL load the new word with no bubble, giving full 1-word/cycle throughput.

Reset
REQ-037 While rst = 1, SHALL asynchronously force state = PACK, fill = 0, residue = 0, out_valid_o = 0, out_data_o = 0, out_strb_o = 0, out_last_o = 0, msg_bytes_o = 0 and err_o = 0.
REQ-038 in_ready_o SHALL be 0 while rst = 1, and SHALL be 1 in the first cycle after rst deasserts.
REQ-039 A reset asserted mid-message (including in FLUSH) SHALL discard all partial data; the first beat after reset starts a new message.

Verification
REQ-040 Bytes 1,3,4(last): beats data 0x11, 0x443322, 0x88776655 with bytes 1, 3, 4(last) -> 0x44332211 strb F last 0, then 0x88776655 strb F last 1; msg_bytes 8.
REQ-041 Overflow on last: bytes 3 then 2(last), data 0x00CCBBAA, 0x0000EEDD -> 0xDDCCBBAA strb F last 0, then FLUSH 0x000000EE strb 1 last 1; in_ready_o = 0 until the second handshake.
REQ-042 Backpressure: out_ready_i = 0 for 5 cycles with 4-byte beats -> output held stable, in_ready_o = 0, no data lost, word order preserved.
REQ-043 Empty message: in_bytes_i = 0, last with fill = 0 -> data 0, strb 0000, last 1; msg_bytes 0.
REQ-044 Illegal beat: in_bytes_i = 5 -> err_o pulses one cycle, fill and msg_bytes_o unchanged.
REQ-045 Abort and reset mid-message: abort_i or rst asserted in FLUSH -> out_valid_o = 0 next cycle; the next 4-byte last beat emits strb F, last 1, msg_bytes 4.

Source files
------------

// File: rtl/sha3_msg_packer.sv
// Packs variable-length little-endian byte beats (0..4 bytes) into full 32-bit
// words for the SHA3 message FIFO, with a single registered output stage.
module sha3_msg_packer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic [2:0]    in_bytes_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [3:0]    out_strb_o,
  output logic          out_last_o,
  output logic [31:0]   msg_bytes_o,
  output logic          err_o
);

  typedef enum logic {PACK, FLUSH} state_t;

  state_t        r_state;
  logic [1:0]    r_fill;
  logic [23:0]   r_res;
  logic          r_vld_p1;
  logic [DW-1:0] r_data_p1;
  logic [3:0]    r_strb_p1;
  logic          r_last_p1;
  logic [31:0]   r_msg_bytes;
  logic          r_err;

  logic          w_out_hs;
  logic          w_in_ready;
  logic          w_acc;
  logic          w_illegal;
  logic          w_legal;
  logic [2:0]    w_total;
  logic [31:0]   w_din;
  logic [55:0]   w_comb;
  logic [31:0]   w_msg_base;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {30'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [3:0] strb_of(input logic [2:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Upper bytes beyond the valid count are zeroed so the residue never carries garbage.
  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    return 32'd0;
      3'd1:    return {24'd0, d[7:0]};
      3'd2:    return {16'd0, d[15:0]};
      3'd3:    return {8'd0, d[23:0]};
      default: return d;
    endcase
  endfunction

  assign w_out_hs   = r_vld_p1 & out_ready_i;
  assign w_in_ready = !rst && !abort_i && (r_state == PACK) && (!r_vld_p1 || out_ready_i);
  assign w_acc      = in_valid_i & w_in_ready;
  assign w_illegal  = (in_bytes_i > 3'd4) || ((in_bytes_i == 3'd0) && !in_last_i);
  assign w_legal    = w_acc & !w_illegal;
  assign w_total    = {1'b0, r_fill} + in_bytes_i;
  assign w_din      = keep_bytes(in_data_i, in_bytes_i);
  assign w_comb     = {32'd0, r_res} | ({24'd0, w_din} << {r_fill, 3'b000});
  assign w_msg_base = (w_out_hs && r_last_p1) ? 32'd0 : r_msg_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PACK;
      r_fill      <= 2'd0;
      r_res       <= 24'd0;
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
      r_strb_p1   <= 4'd0;
      r_last_p1   <= 1'b0;
      r_msg_bytes <= 32'd0;
      r_err       <= 1'b0;
    end else if (abort_i) begin
      r_state     <= PACK;
      r_fill      <= 2'd0;
      r_res       <= 24'd0;
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
      r_strb_p1   <= 4'd0;
      r_last_p1   <= 1'b0;
      r_msg_bytes <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_err       <= w_acc & w_illegal;
      r_msg_bytes <= w_legal ? sat_add(w_msg_base, in_bytes_i) : w_msg_base;
      if (r_state == FLUSH) begin
        // Full word of an overflowing last beat drains; follow it with the residue.
        if (w_out_hs) begin
          r_data_p1 <= {8'd0, r_res};
          r_strb_p1 <= strb_of({1'b0, r_fill});
          r_last_p1 <= 1'b1;
          r_fill    <= 2'd0;
          r_res     <= 24'd0;
          r_state   <= PACK;
        end
      end else begin
        if (w_out_hs) r_vld_p1 <= 1'b0;
        if (w_legal) begin
          if (w_total >= 3'd4) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_comb[31:0];
            r_strb_p1 <= 4'b1111;
            if (in_last_i && (w_total == 3'd4)) begin
              r_last_p1 <= 1'b1;
              r_fill    <= 2'd0;
              r_res     <= 24'd0;
            end else begin
              r_last_p1 <= 1'b0;
              r_fill    <= w_total[1:0];
              r_res     <= w_comb[55:32];
              if (in_last_i) r_state <= FLUSH;
            end
          end else if (in_last_i) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_comb[31:0];
            r_strb_p1 <= strb_of(w_total);
            r_last_p1 <= 1'b1;
            r_fill    <= 2'd0;
            r_res     <= 24'd0;
          end else begin
            r_fill <= w_total[1:0];
            r_res  <= w_comb[23:0];
          end
        end
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_vld_p1;
  assign out_data_o  = r_data_p1;
  assign out_strb_o  = r_strb_p1;
  assign out_last_o  = r_last_p1;
  assign msg_bytes_o = r_msg_bytes;
  assign err_o       = r_err;

endmodule

// File: tb/tb_sha3_msg_packer.sv
// Bench for sha3_msg_packer: directed scenarios plus a randomized run scored
// against a byte-queue model of the message packing rules.
module tb_sha3_msg_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = 32'd0;
  logic [2:0]  in_bytes_i = 3'd0;
  logic        in_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [3:0]  out_strb_o;
  logic        out_last_o;
  logic [31:0] msg_bytes_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  n;
    logic        l;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    logic [31:0] mb;
  } word_t;

  logic [7:0] mq[$];
  word_t      exp_q[$];

  sha3_msg_packer #(.DW(32)) dut (
    .clk(clk), .rst(rst), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_bytes_i(in_bytes_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_strb_o(out_strb_o), .out_last_o(out_last_o),
    .msg_bytes_o(msg_bytes_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] n, input logic l);
    in_valid_i = v;
    in_data_i  = d;
    in_bytes_i = n;
    in_last_i  = l;
  endtask

  // Model: pop k bytes from the message byte queue into one expected output word.
  function automatic void emit(input int k, input logic l, input logic [31:0] mb);
    word_t w;
    w.d = 32'd0;
    w.s = 4'd0;
    for (int i = 0; i < k; i++) begin
      w.d[8*i +: 8] = mq.pop_front();
      w.s[i] = 1'b1;
    end
    w.l  = l;
    w.mb = mb;
    exp_q.push_back(w);
  endfunction

  task automatic test_reset;
    drive(1'b1, 32'hFFFF_FFFF, 3'd4, 1'b1);
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o, err_o} !== 72'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h strb=%b last=%b msg=%0d err=%b required all 0",
               in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o, err_o);
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", in_ready_o);
    end
    tick();
  endtask

  task automatic test_bytes_134;
    out_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0011, 3'd1, 1'b0);
    tick();
    drive(1'b1, 32'h0044_3322, 3'd3, 1'b0);
    tick();
    checks++;
    if ({out_valid_o, out_data_o, out_strb_o, out_last_o} !== {1'b1, 32'h4433_2211, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL b134_word0 got vld=%b data=%h strb=%b last=%b required 1 44332211 1111 0",
               out_valid_o, out_data_o, out_strb_o, out_last_o);
    end
    drive(1'b1, 32'h8877_6655, 3'd4, 1'b1);
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b134_no_bubble got ready=%b required 1", in_ready_o);
    end
    tick();
    checks++;
    if ({out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o} !== {1'b1, 32'h8877_6655, 4'hF, 1'b1, 32'd8}) begin
      errors++;
      $display("FAIL b134_word1 got vld=%b data=%h strb=%b last=%b msg=%0d required 1 88776655 1111 1 8",
               out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o);
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    tick();
    checks++;
    if ({out_valid_o, msg_bytes_o} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL b134_drain got vld=%b msg=%0d required 0 0", out_valid_o, msg_bytes_o);
    end
  endtask

  task automatic test_overflow_last;
    out_ready_i = 1'b1;
    drive(1'b1, 32'h00CC_BBAA, 3'd3, 1'b0);
    tick();
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_no_early_word got vld=%b required 0", out_valid_o);
    end
    drive(1'b1, 32'h0000_EEDD, 3'd2, 1'b1);
    tick();
    checks++;
    if ({out_valid_o, out_data_o, out_strb_o, out_last_o} !== {1'b1, 32'hDDCC_BBAA, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL ovf_word0 got vld=%b data=%h strb=%b last=%b required 1 ddccbbaa 1111 0",
               out_valid_o, out_data_o, out_strb_o, out_last_o);
    end
    out_ready_i = 1'b0;
    drive(1'b1, 32'h1234_5678, 3'd4, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({in_ready_o, out_valid_o, out_data_o} !== {1'b0, 1'b1, 32'hDDCC_BBAA}) begin
        errors++;
        $display("FAIL ovf_flush_hold got rdy=%b vld=%b data=%h required 0 1 ddccbbaa",
                 in_ready_o, out_valid_o, out_data_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flush_ready got %b required 0", in_ready_o);
    end
    tick();
    out_ready_i = 1'b0;
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o} !==
        {1'b0, 1'b1, 32'h0000_00EE, 4'b0001, 1'b1, 32'd5}) begin
      errors++;
      $display("FAIL ovf_word1 got rdy=%b vld=%b data=%h strb=%b last=%b msg=%0d required 0 1 000000ee 0001 1 5",
               in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o);
    end
    tick();
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    out_ready_i = 1'b1;
    tick();
    checks++;
    if ({out_valid_o, msg_bytes_o} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL ovf_drain got vld=%b msg=%0d required 0 0", out_valid_o, msg_bytes_o);
    end
  endtask

  task automatic test_backpressure;
    out_ready_i = 1'b0;
    drive(1'b1, 32'hA3A2_A1A0, 3'd4, 1'b0);
    tick();
    drive(1'b1, 32'hB3B2_B1B0, 3'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o} !== {1'b0, 1'b1, 32'hA3A2_A1A0, 4'hF, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rdy=%b vld=%b data=%h strb=%b last=%b required 0 1 a3a2a1a0 1111 0",
                 i, in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    checks++;
    if ({out_valid_o, out_data_o, out_last_o} !== {1'b1, 32'hB3B2_B1B0, 1'b0}) begin
      errors++;
      $display("FAIL bp_word1 got vld=%b data=%h last=%b required 1 b3b2b1b0 0", out_valid_o, out_data_o, out_last_o);
    end
    drive(1'b1, 32'hC3C2_C1C0, 3'd4, 1'b1);
    tick();
    checks++;
    if ({out_valid_o, out_data_o, out_last_o, msg_bytes_o} !== {1'b1, 32'hC3C2_C1C0, 1'b1, 32'd12}) begin
      errors++;
      $display("FAIL bp_word2 got vld=%b data=%h last=%b msg=%0d required 1 c3c2c1c0 1 12",
               out_valid_o, out_data_o, out_last_o, msg_bytes_o);
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    tick();
  endtask

  task automatic test_empty;
    out_ready_i = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 3'd0, 1'b1);
    tick();
    checks++;
    if ({out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o} !== {1'b1, 32'd0, 4'd0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL empty_marker got vld=%b data=%h strb=%b last=%b msg=%0d required 1 00000000 0000 1 0",
               out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o);
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    tick();
  endtask

  task automatic test_illegal;
    out_ready_i = 1'b1;
    drive(1'b1, 32'hFFFF_FFAB, 3'd1, 1'b0);
    tick();
    drive(1'b1, 32'h5555_5555, 3'd5, 1'b0);
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_accept got ready=%b required 1", in_ready_o);
    end
    tick();
    checks++;
    if ({err_o, out_valid_o, msg_bytes_o} !== {1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL illegal5_err got err=%b vld=%b msg=%0d required 1 0 1", err_o, out_valid_o, msg_bytes_o);
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse got err=%b required 0", err_o);
    end
    drive(1'b1, 32'h6666_6666, 3'd0, 1'b0);
    tick();
    checks++;
    if ({err_o, msg_bytes_o} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL illegal0_err got err=%b msg=%0d required 1 1", err_o, msg_bytes_o);
    end
    drive(1'b1, 32'h99FF_EEDD, 3'd3, 1'b1);
    tick();
    checks++;
    if ({err_o, out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o} !==
        {1'b0, 1'b1, 32'hFFEE_DDAB, 4'hF, 1'b1, 32'd4}) begin
      errors++;
      $display("FAIL illegal_fill_kept got err=%b vld=%b data=%h strb=%b last=%b msg=%0d required 0 1 ffeeddab 1111 1 4",
               err_o, out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o);
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    tick();
  endtask

  task automatic test_abort_reset;
    for (int p = 0; p < 2; p++) begin
      out_ready_i = 1'b0;
      drive(1'b1, 32'h00CC_BBAA, 3'd3, 1'b0);
      tick();
      drive(1'b1, 32'h0000_EEDD, 3'd2, 1'b1);
      tick();
      drive(1'b0, 32'd0, 3'd0, 1'b0);
      checks++;
      if ({out_valid_o, out_last_o} !== {1'b1, 1'b0}) begin
        errors++;
        $display("FAIL kill%0d_setup got vld=%b last=%b required 1 0", p, out_valid_o, out_last_o);
      end
      if (p == 0) abort_i = 1'b1;
      else        rst = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL kill%0d_ready got %b required 0", p, in_ready_o);
      end
      tick();
      abort_i = 1'b0;
      rst = 1'b0;
      checks++;
      if ({out_valid_o, msg_bytes_o} !== {1'b0, 32'd0}) begin
        errors++;
        $display("FAIL kill%0d_clear got vld=%b msg=%0d required 0 0", p, out_valid_o, msg_bytes_o);
      end
      out_ready_i = 1'b1;
      drive(1'b1, 32'h0403_0201, 3'd4, 1'b1);
      tick();
      checks++;
      if ({out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o} !== {1'b1, 32'h0403_0201, 4'hF, 1'b1, 32'd4}) begin
        errors++;
        $display("FAIL kill%0d_restart got vld=%b data=%h strb=%b last=%b msg=%0d required 1 04030201 1111 1 4",
                 p, out_valid_o, out_data_o, out_strb_o, out_last_o, msg_bytes_o);
      end
      drive(1'b0, 32'd0, 3'd0, 1'b0);
      tick();
    end
  endtask

  task automatic test_random;
    beat_t beats[$];
    word_t w;
    logic [31:0] mlen;
    int bi;
    int cyc;
    logic exp_err;
    logic nxt_err;
    mlen = 32'd0;
    mq.delete();
    exp_q.delete();
    for (int k = 0; k < 300; k++) begin
      beat_t b;
      b.d = $urandom;
      b.l = ($urandom_range(0, 4) == 0);
      b.n = 3'($urandom_range(1, 4));
      if (b.l && $urandom_range(0, 5) == 0) b.n = 3'd0;
      if ($urandom_range(0, 14) == 0) begin
        b.n = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(5, 7)) : 3'd0;
        if (b.n == 3'd0) b.l = 1'b0;
      end
      if (k == 299) begin
        b.n = 3'd4;
        b.l = 1'b1;
      end
      beats.push_back(b);
      if (!((b.n > 3'd4) || (b.n == 3'd0 && !b.l))) begin
        for (int i = 0; i < int'(b.n); i++) mq.push_back(b.d[8*i +: 8]);
        mlen = mlen + 32'(b.n);
        if (!b.l) begin
          while (mq.size() >= 4) emit(4, 1'b0, 32'd0);
        end else if (mq.size() == 0) begin
          emit(0, 1'b1, mlen);
          mlen = 32'd0;
        end else begin
          while (mq.size() > 4) emit(4, 1'b0, 32'd0);
          emit(mq.size(), 1'b1, mlen);
          mlen = 32'd0;
        end
      end
    end
    bi = 0;
    cyc = 0;
    exp_err = 1'b0;
    while ((bi < beats.size() || exp_q.size() > 0) && cyc < 20000) begin
      cyc++;
      if (bi < beats.size() && $urandom_range(0, 3) != 0)
        drive(1'b1, beats[bi].d, beats[bi].n, beats[bi].l);
      else
        drive(1'b0, 32'd0, 3'd0, 1'b0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (err_o !== exp_err) begin
        errors++;
        $display("FAIL rand_err cycle %0d got %b required %b", cyc, err_o, exp_err);
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_word got data=%h strb=%b last=%b required no word", out_data_o, out_strb_o, out_last_o);
        end else begin
          w = exp_q.pop_front();
          if ({out_data_o, out_strb_o, out_last_o} !== {w.d, w.s, w.l} || (w.l && msg_bytes_o !== w.mb)) begin
            errors++;
            $display("FAIL rand_word cycle %0d got data=%h strb=%b last=%b msg=%0d required data=%h strb=%b last=%b msg=%0d",
                     cyc, out_data_o, out_strb_o, out_last_o, msg_bytes_o, w.d, w.s, w.l, w.mb);
          end
        end
      end
      nxt_err = 1'b0;
      if (in_valid_i && in_ready_o) begin
        nxt_err = (in_bytes_i > 3'd4) || (in_bytes_i == 3'd0 && !in_last_i);
        bi++;
      end
      @(posedge clk);
      #1;
      exp_err = nxt_err;
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0);
    checks++;
    if (exp_q.size() != 0 || bi != beats.size()) begin
      errors++;
      $display("FAIL rand_timeout got beats=%0d words_left=%0d required beats=%0d words_left=0",
               bi, exp_q.size(), beats.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_bytes_134();
    test_overflow_last();
    test_backpressure();
    test_empty();
    test_illegal();
    test_abort_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
